// File: rtl/mips_instr_fetch.sv
// Instruction fetch unit for a MIPS core: reads one word per pc from the
// instruction memory bus and hands it to decode through a one-entry buffer.
module mips_instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_advance,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        active,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state;

  assign dbg_state = state;

  // Handshake: a transfer to decode happens on the edge where instr_valid and
  // instr_ready are both 1; instr_valid never drops and instr never changes
  // before that edge. A bus read completes on an edge with avm_read=1 and
  // avm_waitrequest=0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      avm_read       <= 1'b0;
      avm_address    <= 32'h0;
      avm_byteenable <= 4'b0000;
      instr          <= 32'h0;
      instr_valid    <= 1'b0;
      pc_advance     <= 1'b0;
      active         <= 1'b0;
      fetch_err      <= 1'b0;
    end else begin
      pc_advance <= 1'b0;
      case (state)
        IDLE: begin
          // active is low only on the first cycle after reset: spend that
          // cycle coming up so the first pc sample is one cycle later.
          if (!active) begin
            active <= 1'b1;
          end else if (pc == 32'h0) begin
            state  <= HALTED;
            active <= 1'b0;
          end else if (pc[1:0] != 2'b00) begin
            state     <= HALTED;
            active    <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            state          <= FETCH;
            avm_address    <= pc;
            avm_read       <= 1'b1;
            avm_byteenable <= 4'b1111;
          end
        end

        FETCH: begin
          if (!avm_waitrequest) begin
            state          <= HOLD;
            instr          <= avm_readdata;
            instr_valid    <= 1'b1;
            avm_read       <= 1'b0;
            avm_byteenable <= 4'b0000;
            pc_advance     <= 1'b1;
          end
        end

        HOLD: begin
          if (instr_ready) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
          end
        end

        HALTED: begin
          avm_read       <= 1'b0;
          avm_byteenable <= 4'b0000;
          instr_valid    <= 1'b0;
          active         <= 1'b0;
        end

        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_fetch.sv
// Bench for mips_instr_fetch: directed vector table, hand-written reset and
// halt sequences, and a randomized run against a transaction-level model.
module tb_mips_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pc_advance;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        active;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    int          nwait;
    int          nhold;
    logic [31:0] rdata;
    int          exp_reads;
    int          exp_adv;
    logic        exp_err;
    logic        exp_active;
  } vec_t;

  vec_t vecs[8];

  mips_instr_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_advance      (pc_advance),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .active          (active),
    .fetch_err       (fetch_err),
    .dbg_state       (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, "_addr"}, avm_address, 32'h0);
    check({name, "_instr"}, instr, 32'h0);
    check({name, "_ctl"}, 32'({avm_read, avm_byteenable, instr_valid, pc_advance, active, fetch_err}), 32'h0);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst = 1'b0;
    avm_waitrequest = 1'b0;
    instr_ready = 1'b0;
    pc = start_pc;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();
    check("post_reset_active", 32'(active), 32'h1);
    check("post_reset_read", 32'(avm_read), 32'h0);
  endtask

  task automatic run_vector(input vec_t v);
    int rd_cycles;
    int adv;
    int hold;
    logic hs;
    logic done;
    do_reset(v.pc);
    avm_readdata = v.rdata;
    rd_cycles = 0;
    adv = 0;
    hold = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (avm_read) begin
        rd_cycles++;
        check("vec_addr", avm_address, v.pc);
      end
      if (pc_advance) adv++;
      if (instr_valid) begin
        hold++;
        check("vec_instr", instr, v.rdata);
      end
      avm_waitrequest = avm_read && (rd_cycles <= v.nwait);
      instr_ready = instr_valid && (hold > v.nhold);
      hs = instr_valid && instr_ready;
      tick();
      if (hs) begin
        check("vec_valid_drop", 32'(instr_valid), 32'h0);
        done = 1'b1;
      end
    end
    check("vec_read_cycles", rd_cycles, v.exp_reads);
    check("vec_adv_count", adv, v.exp_adv);
    check("vec_fetch_err", 32'(fetch_err), 32'(v.exp_err));
    check("vec_active", 32'(active), 32'(v.exp_active));
    check("vec_read_end", 32'(avm_read), 32'h0);
    check("vec_done", 32'(done), 32'(v.exp_adv == 1));
  endtask

  // Randomized-run bookkeeping
  logic [31:0] base;
  int          nreads;
  int          n_adv;
  int          n_acc;
  logic        prev_rd, prev_wait, prev_iv, prev_hs, accept_prev;
  logic        pa_now, accept, hs;
  logic [31:0] prev_addr, prev_ins;

  initial begin
    vecs[0] = '{32'hBFC0_0000, 0, 0, 32'h2402_0005, 1, 1, 1'b0, 1'b1};
    vecs[1] = '{32'h0040_0000, 3, 0, 32'h8FBF_0010, 4, 1, 1'b0, 1'b1};
    vecs[2] = '{32'h0040_0010, 0, 5, 32'hAFBF_0014, 1, 1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 0, 0, 32'h1111_1111, 0, 0, 1'b0, 1'b0};
    vecs[4] = '{32'hBFC0_0002, 0, 0, 32'h2222_2222, 0, 0, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0001, 0, 0, 32'h3333_3333, 0, 0, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0004, 2, 2, 32'hFFFF_FFFF, 3, 1, 1'b0, 1'b1};
    vecs[7] = '{32'h8000_0003, 1, 1, 32'h4444_4444, 0, 0, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) run_vector(vecs[i]);

    // Exact cycle timing of the first fetch after reset
    do_reset(32'hBFC0_0000);
    avm_readdata = 32'h2402_0005;
    instr_ready = 1'b1;
    tick();
    check("t40_read", 32'(avm_read), 32'h1);
    check("t40_addr", avm_address, 32'hBFC0_0000);
    check("t40_be", 32'(avm_byteenable), 32'hF);
    check("t40_adv_early", 32'(pc_advance), 32'h0);
    tick();
    check("t40_read_drop", 32'(avm_read), 32'h0);
    check("t40_instr", instr, 32'h2402_0005);
    check("t40_valid", 32'(instr_valid), 32'h1);
    check("t40_adv", 32'(pc_advance), 32'h1);
    tick();
    check("t40_adv_once", 32'(pc_advance), 32'h0);
    check("t40_valid_drop", 32'(instr_valid), 32'h0);
    check("t40_active", 32'(active), 32'h1);
    tick();
    check("t40_refetch", 32'(avm_read), 32'h1);

    // Misaligned pc is sticky until reset, even after pc becomes valid
    do_reset(32'hBFC0_0002);
    tick();
    check("t44_err", 32'(fetch_err), 32'h1);
    check("t44_active", 32'(active), 32'h0);
    pc = 32'h0000_0100;
    for (int i = 0; i < 5; i++) tick();
    check("t44_err_sticky", 32'(fetch_err), 32'h1);
    check("t44_no_read", 32'(avm_read), 32'h0);
    rst = 1'b0;
    tick();
    check("t44_err_cleared", 32'(fetch_err), 32'h0);

    // Reset during a stalled read abandons it
    do_reset(32'h0000_0100);
    avm_waitrequest = 1'b1;
    avm_readdata = 32'hDEAD_BEEF;
    tick();
    check("t45_read", 32'(avm_read), 32'h1);
    tick();
    tick();
    check("t45_addr_stable", avm_address, 32'h0000_0100);
    rst = 1'b0;
    tick();
    check_reset_outputs("t45_reset");
    rst = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h1234_5678;
    pc = 32'h0000_0200;
    tick();
    check("t45_active", 32'(active), 32'h1);
    check("t45_no_read_yet", 32'(avm_read), 32'h0);
    tick();
    check("t45_restart_addr", avm_address, 32'h0000_0200);
    check("t45_restart_read", 32'(avm_read), 32'h1);
    tick();
    check("t45_new_instr", instr, 32'h1234_5678);
    check("t45_adv", 32'(pc_advance), 32'h1);

    // Reset while an instruction is buffered discards it
    do_reset(32'h0000_0300);
    avm_readdata = 32'hCAFE_F00D;
    tick();
    tick();
    check("t32_adv", 32'(pc_advance), 32'h1);
    tick();
    check("t32_held", 32'(instr_valid), 32'h1);
    rst = 1'b0;
    tick();
    check("t32_adv_none", 32'(pc_advance), 32'h0);
    check("t32_valid", 32'(instr_valid), 32'h0);
    check("t32_instr", instr, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    check("t32_restart", avm_address, 32'h0000_0300);

    // Randomized run: tb acts as program counter and memory
    base = 32'h0040_0000;
    do_reset(base);
    exp_q.delete();
    nreads = 0;
    n_adv = 0;
    n_acc = 0;
    prev_rd = 1'b0;
    prev_wait = 1'b0;
    prev_iv = 1'b0;
    prev_hs = 1'b0;
    accept_prev = 1'b0;
    prev_addr = 32'h0;
    prev_ins = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pa_now = pc_advance;
      check("rand_be", 32'(avm_byteenable), avm_read ? 32'hF : 32'h0);
      check("rand_overlap", 32'(avm_read & instr_valid), 32'h0);
      check("rand_adv_timing", 32'(pc_advance), 32'(accept_prev));
      if (avm_read && !prev_rd) begin
        check("rand_addr", avm_address, base + 32'(nreads * 4));
        nreads++;
      end
      if (avm_read && prev_rd && prev_wait) check("rand_addr_hold", avm_address, prev_addr);
      if (prev_iv && !prev_hs) begin
        check("rand_valid_hold", 32'(instr_valid), 32'h1);
        check("rand_instr_hold", instr, prev_ins);
      end
      avm_waitrequest = ($urandom_range(0, 2) != 0);
      avm_readdata = avm_read ? mem_word(avm_address) : $urandom();
      instr_ready = ($urandom_range(0, 1) == 1);
      accept = avm_read && !avm_waitrequest;
      hs = instr_valid && instr_ready;
      if (accept) begin
        exp_q.push_back(mem_word(avm_address));
        n_acc++;
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_instr: got %h expected none (queue empty)", instr);
        end else begin
          check("rand_instr", instr, exp_q.pop_front());
        end
      end
      if (pa_now) n_adv++;
      prev_rd = avm_read;
      prev_wait = avm_waitrequest;
      prev_addr = avm_address;
      prev_iv = instr_valid;
      prev_ins = instr;
      prev_hs = hs;
      accept_prev = accept;
      tick();
      if (pa_now) pc = pc + 32'd4;
    end
    check("rand_adv_count", n_adv, n_acc - int'(accept_prev));
    check("rand_progress", 32'(n_acc > 100), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
